// File: rtl/rab_inv_range_ctrl.sv
// RAB L1 invalidation responder: AXI-Lite range registers plus an overlap sweep of the slice table.
// Optional INV_HITS counter at 0x20 is enabled by defining RAB_INV_COUNT_EN.
module rab_inv_range_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned N_SLICES   = 16,
   localparam int unsigned IDX_W     = (N_SLICES > 1) ? $clog2(N_SLICES) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [ADDR_WIDTH-1:0]   aw_addr_i,
   input  logic                    aw_valid_i,
   output logic                    aw_ready_o,
   input  logic [DATA_WIDTH-1:0]   w_data_i,
   input  logic [DATA_WIDTH/8-1:0] w_strb_i,
   input  logic                    w_valid_i,
   output logic                    w_ready_o,
   output logic [1:0]              b_resp_o,
   output logic                    b_valid_o,
   input  logic                    b_ready_i,
   input  logic [ADDR_WIDTH-1:0]   ar_addr_i,
   input  logic                    ar_valid_i,
   output logic                    ar_ready_o,
   output logic [DATA_WIDTH-1:0]   r_data_o,
   output logic [1:0]              r_resp_o,
   output logic                    r_valid_o,
   input  logic                    r_ready_i,
   output logic                    slice_req_o,
   output logic [IDX_W-1:0]        slice_idx_o,
   input  logic [ADDR_WIDTH-1:0]   slice_first_i,
   input  logic [ADDR_WIDTH-1:0]   slice_last_i,
   input  logic                    slice_en_i,
   output logic                    slice_clr_o,
   output logic [IDX_W-1:0]        slice_clr_idx_o,
   output logic                    busy_o
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StSweep = 2'd1;
   localparam logic [1:0] StResp  = 2'd2;
   localparam logic [1:0] StRdata = 2'd3;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_SLICES - 1);

   logic [1:0]            state_q;
   logic [ADDR_WIDTH-1:0] min_q, max_q;
   logic                  req_q, cmp_q;
   logic [IDX_W-1:0]      idx_q, cmp_idx_q;
   logic                  b_valid_q, r_valid_q;
   logic [1:0]            b_resp_q, r_resp_q;
   logic [DATA_WIDTH-1:0] r_data_q;
`ifdef RAB_INV_COUNT_EN
   logic [15:0]           hits_q;
`endif

   logic                  idle, wr_fire, rd_fire, hit, rd_err;
   logic [7:0]            wa, ra;
   logic [ADDR_WIDTH-1:0] wr_min_new, wr_max_new;
   logic [DATA_WIDTH-1:0] rd_data;

   function automatic logic [ADDR_WIDTH-1:0] merge_bytes(input logic [ADDR_WIDTH-1:0]   old,
                                                         input logic [ADDR_WIDTH-1:0]   data,
                                                         input logic [ADDR_WIDTH/8-1:0] strb);
      logic [ADDR_WIDTH-1:0] res;
      res = old;
      for (int unsigned i = 0; i < ADDR_WIDTH / 8; i++) begin
         if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
      end
      return res;
   endfunction

   // Writes take priority: a read is only accepted when neither write channel is valid.
   assign idle       = rst_ni && (state_q == StIdle);
   assign wr_fire    = idle && aw_valid_i && w_valid_i;
   assign ar_ready_o = idle && !aw_valid_i && !w_valid_i;
   assign rd_fire    = ar_ready_o && ar_valid_i;
   assign aw_ready_o = wr_fire;
   assign w_ready_o  = wr_fire;

   assign wa         = aw_addr_i[7:0];
   assign ra         = ar_addr_i[7:0];
   assign wr_min_new = merge_bytes(min_q, w_data_i[ADDR_WIDTH-1:0], w_strb_i[ADDR_WIDTH/8-1:0]);
   assign wr_max_new = merge_bytes(max_q, w_data_i[ADDR_WIDTH-1:0], w_strb_i[ADDR_WIDTH/8-1:0]);

   // Slice data arrives one cycle after its request, so the clear is qualified by cmp_q.
   assign hit = cmp_q && slice_en_i && (slice_first_i <= max_q) && (slice_last_i >= min_q);

   assign slice_clr_o     = hit;
   assign slice_clr_idx_o = cmp_idx_q;
   assign slice_req_o     = req_q;
   assign slice_idx_o     = idx_q;
   assign busy_o          = (state_q == StSweep);
   assign b_valid_o       = b_valid_q;
   assign b_resp_o        = b_resp_q;
   assign r_valid_o       = r_valid_q;
   assign r_resp_o        = r_resp_q;
   assign r_data_o        = r_data_q;

   always_comb begin
      rd_data = '0;
      rd_err  = 1'b0;
      case (ra)
         8'h10:   rd_data[ADDR_WIDTH-1:0] = min_q;
         8'h18:   rd_data[ADDR_WIDTH-1:0] = max_q;
`ifdef RAB_INV_COUNT_EN
         8'h20:   rd_data[15:0] = hits_q;
`endif
         default: rd_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         min_q     <= '0;
         max_q     <= '0;
         req_q     <= 1'b0;
         cmp_q     <= 1'b0;
         idx_q     <= '0;
         cmp_idx_q <= '0;
         b_valid_q <= 1'b0;
         b_resp_q  <= RespOkay;
         r_valid_q <= 1'b0;
         r_resp_q  <= RespOkay;
         r_data_q  <= '0;
`ifdef RAB_INV_COUNT_EN
         hits_q    <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (wr_fire) begin
                  state_q   <= StResp;
                  b_valid_q <= 1'b1;
                  b_resp_q  <= RespSlverr;
                  case (wa)
                     8'h10: begin
                        min_q    <= wr_min_new;
                        b_resp_q <= RespOkay;
                     end
                     8'h18: begin
                        max_q <= wr_max_new;
                        if (wr_max_new >= min_q) begin
                           state_q   <= StSweep;
                           b_valid_q <= 1'b0;
                           req_q     <= 1'b1;
                           idx_q     <= '0;
                           cmp_q     <= 1'b0;
`ifdef RAB_INV_COUNT_EN
                           hits_q    <= '0;
`endif
                        end
                     end
                     default: ;
                  endcase
               end else if (rd_fire) begin
                  state_q   <= StRdata;
                  r_valid_q <= 1'b1;
                  r_data_q  <= rd_data;
                  r_resp_q  <= rd_err ? RespSlverr : RespOkay;
               end
            end
            StSweep: begin
               cmp_q     <= req_q;
               cmp_idx_q <= idx_q;
               if (req_q) begin
                  if (idx_q == LastIdx) req_q <= 1'b0;
                  else                  idx_q <= idx_q + 1'b1;
               end
`ifdef RAB_INV_COUNT_EN
               if (hit && (hits_q != 16'hFFFF)) hits_q <= hits_q + 16'd1;
`endif
               if (cmp_q && (cmp_idx_q == LastIdx)) begin
                  state_q   <= StResp;
                  cmp_q     <= 1'b0;
                  b_valid_q <= 1'b1;
                  b_resp_q  <= RespOkay;
               end
            end
            StResp: begin
               if (b_ready_i) begin
                  b_valid_q <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            StRdata: begin
               if (r_ready_i) begin
                  r_valid_q <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   logic unused_bits;
   assign unused_bits = ^{aw_addr_i[ADDR_WIDTH-1:8], ar_addr_i[ADDR_WIDTH-1:8],
                          w_data_i[DATA_WIDTH-1:ADDR_WIDTH], w_strb_i[DATA_WIDTH/8-1:ADDR_WIDTH/8]};

endmodule

// File: tb/tb_rab_inv_range_ctrl.sv
// Bench for rab_inv_range_ctrl: directed scenarios plus random ranges against a slice-table model.
module tb_rab_inv_range_ctrl;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 64;
   localparam int unsigned NS = 4;
   localparam int unsigned IW = 2;
   localparam logic [1:0] OKAY = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic [AW-1:0] aw_addr, ar_addr;
   logic          aw_valid, w_valid, ar_valid, b_ready, r_ready;
   logic [DW-1:0] w_data;
   logic [7:0]    w_strb;
   logic          aw_ready, w_ready, ar_ready, b_valid, r_valid;
   logic [1:0]    b_resp, r_resp;
   logic [DW-1:0] r_data;
   logic          slice_req, slice_clr, busy;
   logic [IW-1:0] slice_idx, slice_clr_idx;
   logic [AW-1:0] rd_first, rd_last;
   logic          rd_en;

   rab_inv_range_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_SLICES(NS)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .aw_addr_i(aw_addr), .aw_valid_i(aw_valid), .aw_ready_o(aw_ready),
      .w_data_i(w_data), .w_strb_i(w_strb), .w_valid_i(w_valid), .w_ready_o(w_ready),
      .b_resp_o(b_resp), .b_valid_o(b_valid), .b_ready_i(b_ready),
      .ar_addr_i(ar_addr), .ar_valid_i(ar_valid), .ar_ready_o(ar_ready),
      .r_data_o(r_data), .r_resp_o(r_resp), .r_valid_o(r_valid), .r_ready_i(r_ready),
      .slice_req_o(slice_req), .slice_idx_o(slice_idx),
      .slice_first_i(rd_first), .slice_last_i(rd_last), .slice_en_i(rd_en),
      .slice_clr_o(slice_clr), .slice_clr_idx_o(slice_clr_idx), .busy_o(busy)
   );

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;

   // Slice table: staged by the stimulus, latched into tbl_en when load_gen moves.
   logic [AW-1:0] st_first [NS];
   logic [AW-1:0] st_last [NS];
   logic          st_en [NS];
   logic          tbl_en [NS];
   int            load_gen = 0;
   int            load_seen = 0;
   int req_cyc[$], req_idx[$], clr_cyc[$], clr_idx[$], busy_cyc[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (slice_req) begin
         req_cyc.push_back(cyc);
         req_idx.push_back(int'(slice_idx));
         rd_first <= st_first[slice_idx];
         rd_last  <= st_last[slice_idx];
         rd_en    <= tbl_en[slice_idx];
      end
      if (slice_clr) begin
         clr_cyc.push_back(cyc);
         clr_idx.push_back(int'(slice_clr_idx));
      end
      if (busy) busy_cyc.push_back(cyc);
      if (load_gen != load_seen) begin
         for (int k = 0; k < NS; k++) tbl_en[k] <= st_en[k];
         load_seen <= load_gen;
      end else if (slice_clr) begin
         tbl_en[slice_clr_idx] <= 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic load_table(input logic [AW-1:0] f0, l0, f1, l1, f2, l2, f3, l3,
                             input logic [3:0] en);
      st_first[0] = f0; st_last[0] = l0; st_first[1] = f1; st_last[1] = l1;
      st_first[2] = f2; st_last[2] = l2; st_first[3] = f3; st_last[3] = l3;
      for (int k = 0; k < NS; k++) st_en[k] = en[k];
      load_gen++;
      @(negedge clk);
   endtask

   task automatic wr_start(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [7:0] strb, output int t);
      aw_addr = addr; w_data = data; w_strb = strb;
      aw_valid = 1'b1; w_valid = 1'b1;
      #1;
      chk("aw_ready", 64'(aw_ready), 64'd1);
      chk("w_ready", 64'(w_ready), 64'd1);
      t = cyc;
      @(negedge clk);
      aw_valid = 1'b0; w_valid = 1'b0;
   endtask

   task automatic wait_b(input int t, input int lat, input logic [1:0] resp, input string tag);
      int k = 0;
      while (!b_valid && k < 40) begin
         @(negedge clk);
         k++;
      end
      chk({tag, " b_latency"}, 64'(cyc - t), 64'(lat));
      chk({tag, " b_resp"}, 64'(b_resp), 64'(resp));
   endtask

   task automatic b_handshake(input string tag);
      b_ready = 1'b1;
      @(negedge clk);
      b_ready = 1'b0;
      chk({tag, " b_valid_drop"}, 64'(b_valid), 64'd0);
   endtask

   task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [7:0] strb,
                     input int lat, input logic [1:0] resp, input string tag, output int t);
      wr_start(addr, data, strb, t);
      wait_b(t, lat, resp, tag);
      b_handshake(tag);
   endtask

   task automatic rd(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data,
                     input logic [1:0] exp_resp, input string tag);
      ar_addr = addr; ar_valid = 1'b1;
      #1;
      chk({tag, " ar_ready"}, 64'(ar_ready), 64'd1);
      @(negedge clk);
      ar_valid = 1'b0;
      chk({tag, " r_valid"}, 64'(r_valid), 64'd1);
      chk({tag, " r_data"}, r_data, exp_data);
      chk({tag, " r_resp"}, 64'(r_resp), 64'(exp_resp));
      r_ready = 1'b1;
      @(negedge clk);
      r_ready = 1'b0;
   endtask

   // Expected sweep: every enabled slice overlapping [mn, mx] is cleared, in index order,
   // two cycles after the handshake plus its index; requests run t+1..t+NS.
   task automatic check_sweep(input int t, input int r0, input int c0, input int b0,
                              input logic [AW-1:0] mn, input logic [AW-1:0] mx, input string tag);
      int exp_idx[$];
      for (int k = 0; k < NS; k++)
         if (st_en[k] && st_first[k] <= mx && st_last[k] >= mn) exp_idx.push_back(k);
      chk({tag, " n_req"}, 64'(req_cyc.size() - r0), 64'(NS));
      for (int i = 0; i < NS; i++) begin
         if (r0 + i < req_cyc.size()) begin
            chk({tag, " req_cyc"}, 64'(req_cyc[r0+i]), 64'(t + 1 + i));
            chk({tag, " req_idx"}, 64'(req_idx[r0+i]), 64'(i));
         end
      end
      chk({tag, " n_clr"}, 64'(clr_cyc.size() - c0), 64'(exp_idx.size()));
      for (int i = 0; i < exp_idx.size(); i++) begin
         if (c0 + i < clr_cyc.size()) begin
            chk({tag, " clr_idx"}, 64'(clr_idx[c0+i]), 64'(exp_idx[i]));
            chk({tag, " clr_cyc"}, 64'(clr_cyc[c0+i]), 64'(t + 2 + exp_idx[i]));
         end
      end
      chk({tag, " n_busy"}, 64'(busy_cyc.size() - b0), 64'(NS + 1));
      if (busy_cyc.size() > b0) chk({tag, " busy_first"}, 64'(busy_cyc[b0]), 64'(t + 1));
   endtask

   initial begin
      int t, r0, c0, b0;
      logic [AW-1:0] mn, mx;
      logic [AW-1:0] f [NS];
      logic [AW-1:0] l [NS];
      logic [3:0]    en;

      rst_n = 1'b0;
      aw_addr = '0; ar_addr = '0; w_data = '0; w_strb = '0;
      aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
      for (int k = 0; k < NS; k++) begin
         st_first[k] = '0; st_last[k] = '0; st_en[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk("rst b_valid", 64'(b_valid), 64'd0);
      chk("rst r_valid", 64'(r_valid), 64'd0);
      chk("rst slice_req", 64'(slice_req), 64'd0);
      chk("rst slice_clr", 64'(slice_clr), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      rd(32'h10, 64'd0, OKAY, "rst min");
      rd(32'h18, 64'd0, OKAY, "rst max");

      // Basic overlap sweep
      load_table(32'h0, 32'h0FFF, 32'h1000, 32'h1FFF, 32'h1800, 32'h2FFF, 32'h3000, 32'h3FFF, 4'hF);
      wr(32'h10, 64'h1000, 8'hFF, 1, OKAY, "min", t);
      r0 = req_cyc.size(); c0 = clr_cyc.size(); b0 = busy_cyc.size();
      wr_start(32'h18, 64'h1FFF, 8'hFF, t);
      wait_b(t, 6, OKAY, "sweep1");
      b_handshake("sweep1");
      check_sweep(t, r0, c0, b0, 32'h1000, 32'h1FFF, "sweep1");
      if (clr_idx.size() >= c0 + 2) begin
         chk("sweep1 first clear", 64'(clr_idx[c0]), 64'd1);
         chk("sweep1 second clear", 64'(clr_idx[c0+1]), 64'd2);
      end

      // Same range with slice 1 disabled
      load_table(32'h0, 32'h0FFF, 32'h1000, 32'h1FFF, 32'h1800, 32'h2FFF, 32'h3000, 32'h3FFF, 4'hD);
      r0 = req_cyc.size(); c0 = clr_cyc.size(); b0 = busy_cyc.size();
      wr(32'h18, 64'h1FFF, 8'hFF, NS + 2, OKAY, "sweep2", t);
      check_sweep(t, r0, c0, b0, 32'h1000, 32'h1FFF, "sweep2");
`ifdef RAB_INV_COUNT_EN
      rd(32'h20, 64'd1, OKAY, "hits");
`else
      rd(32'h20, 64'd0, SLVERR, "hits unmapped");
`endif

      // max < min: error, no sweep
      wr(32'h10, 64'h2000, 8'hFF, 1, OKAY, "min2", t);
      r0 = req_cyc.size(); b0 = busy_cyc.size();
      wr(32'h18, 64'h1000, 8'hFF, 1, SLVERR, "inverted", t);
      chk("inverted no req", 64'(req_cyc.size() - r0), 64'd0);
      chk("inverted no busy", 64'(busy_cyc.size() - b0), 64'd0);

      // Unmapped write, strobes, unmapped read
      wr(32'h40, 64'h5555, 8'hFF, 1, SLVERR, "wr 0x40", t);
      rd(32'h10, 64'h2000, OKAY, "min kept");
      rd(32'h18, 64'h1000, OKAY, "max updated");
      wr(32'h10, 64'hFFFF_FFFF_FFFF_ABCD, 8'h03, 1, OKAY, "strb", t);
      rd(32'h10, 64'hABCD, OKAY, "strb min");
      wr(32'h20, 64'h1, 8'hFF, 1, SLVERR, "wr 0x20", t);
      rd(32'h40, 64'd0, SLVERR, "rd 0x40");

      // Reset in the middle of a sweep
      wr(32'h10, 64'h0, 8'hFF, 1, OKAY, "min0", t);
      load_table(32'h0, 32'h0FFF, 32'h1000, 32'h1FFF, 32'h1800, 32'h2FFF, 32'h3000, 32'h3FFF, 4'hF);
      wr_start(32'h18, 64'hFFFF, 8'hFF, t);
      @(negedge clk);
      @(negedge clk);
      chk("midrst cycle", 64'(cyc - t), 64'd3);
      chk("midrst req", 64'(slice_req), 64'd1);
      chk("midrst idx", 64'(slice_idx), 64'd2);
      rst_n = 1'b0;
      @(negedge clk);
      chk("midrst b_valid", 64'(b_valid), 64'd0);
      chk("midrst r_valid", 64'(r_valid), 64'd0);
      chk("midrst req0", 64'(slice_req), 64'd0);
      chk("midrst clr", 64'(slice_clr), 64'd0);
      chk("midrst busy", 64'(busy), 64'd0);
      chk("midrst aw_ready", 64'(aw_ready), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      rd(32'h18, 64'd0, OKAY, "midrst max");
      load_table(32'h0, 32'h0FFF, 32'h1000, 32'h1FFF, 32'h1800, 32'h2FFF, 32'h3000, 32'h3FFF, 4'hB);
      r0 = req_cyc.size(); c0 = clr_cyc.size(); b0 = busy_cyc.size();
      wr(32'h18, 64'h3FFF, 8'hFF, NS + 2, OKAY, "postrst", t);
      check_sweep(t, r0, c0, b0, 32'h0, 32'h3FFF, "postrst");

      // B back-pressure blocks all new requests
      load_table(32'h0, 32'h0FFF, 32'h1000, 32'h1FFF, 32'h1800, 32'h2FFF, 32'h3000, 32'h3FFF, 4'hF);
      wr_start(32'h18, 64'h1FFF, 8'hFF, t);
      wait_b(t, NS + 2, OKAY, "bp");
      for (int i = 0; i < 5; i++) begin
         aw_valid = 1'b1; w_valid = 1'b1; ar_valid = 1'b1; ar_addr = 32'h10;
         #1;
         chk("bp b_valid", 64'(b_valid), 64'd1);
         chk("bp aw_ready", 64'(aw_ready), 64'd0);
         chk("bp w_ready", 64'(w_ready), 64'd0);
         chk("bp ar_ready", 64'(ar_ready), 64'd0);
         @(negedge clk);
      end
      aw_valid = 1'b0; w_valid = 1'b0; ar_valid = 1'b0;
      b_handshake("bp");

      // Random ranges against the overlap model
      for (int it = 0; it < 12; it++) begin
         for (int k = 0; k < NS; k++) begin
            f[k] = AW'($urandom_range(0, 32'hFFF));
            l[k] = f[k] + AW'($urandom_range(0, 32'h3FF));
         end
         en = 4'($urandom_range(0, 15));
         load_table(f[0], l[0], f[1], l[1], f[2], l[2], f[3], l[3], en);
         mn = AW'($urandom_range(0, 32'hFFF));
         mx = AW'($urandom_range(0, 32'h13FF));
         wr(32'h10, {32'($urandom), mn}, 8'hFF, 1, OKAY, "rnd min", t);
         r0 = req_cyc.size(); c0 = clr_cyc.size(); b0 = busy_cyc.size();
         if (mx < mn) begin
            wr(32'h18, {32'($urandom), mx}, 8'hFF, 1, SLVERR, "rnd inv", t);
            chk("rnd inv no req", 64'(req_cyc.size() - r0), 64'd0);
         end else begin
            wr(32'h18, {32'($urandom), mx}, 8'hFF, NS + 2, OKAY, "rnd", t);
            check_sweep(t, r0, c0, b0, mn, mx, "rnd");
         end
         rd(32'h18, 64'(mx), OKAY, "rnd max");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
